// File: rtl/fir_error_monitor.sv
// Compares approximate and exact FIR outputs over a window of 2^WIN_LOG2 accepted samples.
// Reports error sum, max, count and mean two edges after the last sample, with a one-cycle done pulse.
module fir_error_monitor #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 8,
  localparam int ACC_W   = WIDTH + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    approx,
  input  logic [WIDTH-1:0]    exact,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    sum_err,
  output logic [WIDTH-1:0]    max_err,
  output logic [WIN_LOG2:0]   err_cnt,
  output logic [WIDTH-1:0]    mean_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state;
  logic [WIN_LOG2-1:0] smp_cnt;
  logic                p1_vld;
  logic [WIDTH-1:0]    p1_d;
  logic                p1_nz;
  logic [ACC_W-1:0]    acc;
  logic [WIDTH-1:0]    max_acc;
  logic [WIN_LOG2:0]   cnt_acc;
  logic                accept;
  logic                last_smp;
  logic [WIDTH-1:0]    abs_diff;

  assign accept   = (state == S_RUN) && in_valid;
  assign last_smp = (smp_cnt == {WIN_LOG2{1'b1}});
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

  always_comb begin
    abs_diff = '0;
    if (approx >= exact) abs_diff = approx - exact;
    else                 abs_diff = exact - approx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (accept && last_smp) state <= S_DRAIN;
        // Stay in DRAIN until stage 2 has absorbed the final difference.
        S_DRAIN: if (!p1_vld) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1: register per-sample error and count accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld  <= 1'b0;
      p1_d    <= '0;
      p1_nz   <= 1'b0;
      smp_cnt <= '0;
    end else begin
      p1_vld <= accept;
      if (state == S_IDLE && start) begin
        smp_cnt <= '0;
      end else if (accept) begin
        p1_d    <= abs_diff;
        p1_nz   <= (approx != exact);
        smp_cnt <= smp_cnt + 1'b1;
      end
    end
  end

  // Stage 2: window accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      max_acc <= '0;
      cnt_acc <= '0;
    end else if (state == S_IDLE && start) begin
      acc     <= '0;
      max_acc <= '0;
      cnt_acc <= '0;
    end else if (p1_vld) begin
      acc     <= acc + ACC_W'(p1_d);
      cnt_acc <= cnt_acc + (WIN_LOG2 + 1)'(p1_nz);
      if (p1_d > max_acc) max_acc <= p1_d;
    end
  end

  // Results persist until the next completed window or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_err  <= '0;
      max_err  <= '0;
      err_cnt  <= '0;
      mean_err <= '0;
    end else if (state == S_DRAIN && !p1_vld) begin
      sum_err  <= acc;
      max_err  <= max_acc;
      err_cnt  <= cnt_acc;
      mean_err <= acc[ACC_W-1:WIN_LOG2];
    end
  end

endmodule
